// File: rtl/systolic_result_drain_pkg.sv
// Shared systolic definitions: S5.10 element format and the result-drain FSM encoding.
package systolic_result_drain_pkg;

  localparam int unsigned DataWidth = 16;
  localparam int unsigned DataFrac  = 10;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFlush
  } drain_state_e;

endpackage

// File: rtl/systolic_result_drain_if.sv
// Output beat stream of the result drain: valid/ready handshake with row and matrix markers.
interface systolic_result_drain_if
  import systolic_result_drain_pkg::*;
#(
  parameter int unsigned LANES      = 8,
  parameter int unsigned DATA_WIDTH = DataWidth
);

  logic                        m_valid;
  logic                        m_ready;
  logic [LANES*DATA_WIDTH-1:0] m_data;
  logic                        m_row_last;
  logic                        m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_row_last,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_row_last,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/systolic_drain_addr_gen.sv
// Maps a (row, beat) position onto the LANES consecutive elements of the flattened matrix.
module systolic_drain_addr_gen
  import systolic_result_drain_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 64,
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned LANES      = 8,
  parameter int unsigned ROW_W      = 6,
  parameter int unsigned BEAT_W     = 3
) (
  input  logic [ROW_W-1:0]                           row,
  input  logic [BEAT_W-1:0]                          beat,
  input  logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] matrix,
  output logic [LANES*DATA_WIDTH-1:0]                lanes
);

  always_comb begin
    lanes = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      // Shift rather than part-select so the index width never has to match the vector size.
      lanes[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(matrix >>
          ((32'(row) * ARRAY_SIZE + 32'(beat) * LANES + k) * DATA_WIDTH));
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Drains a completed systolic-array result as LANES-wide row-major beats.
// Define SYSTOLIC_DRAIN_CAPTURE_EN to snapshot the matrix and free the array immediately.
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 64,
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned LANES      = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       result_valid,
  input  logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] result_flat,
  output logic                                       array_hold,
  output logic                                       overrun,
  systolic_result_drain_if.master                    m
);

  localparam int unsigned Beats  = ARRAY_SIZE / LANES;
  localparam int unsigned RowW   = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int unsigned BeatW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned MatW   = DATA_WIDTH * ARRAY_SIZE * ARRAY_SIZE;
  localparam logic [RowW-1:0]  RowMax  = RowW'(ARRAY_SIZE - 1);
  localparam logic [BeatW-1:0] BeatMax = BeatW'(Beats - 1);

  if (ARRAY_SIZE % LANES != 0) begin : g_bad_lanes
    $error("ARRAY_SIZE must be a multiple of LANES");
  end

  drain_state_e            state_q, state_d;
  logic [RowW-1:0]         row_q, row_d;
  logic [BeatW-1:0]        beat_q, beat_d;
  logic                    overrun_q, overrun_d;
  logic                    xfer;
  logic                    accept;
  logic [MatW-1:0]         src;
  logic [LANES*DATA_WIDTH-1:0] lane_data;

  assign accept = (state_q == StIdle) && result_valid;
  assign xfer   = m.m_valid && m.m_ready;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    beat_d    = beat_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (result_valid) begin
          state_d = StStream;
          row_d   = '0;
          beat_d  = '0;
        end
      end
      StStream: begin
        if (result_valid) overrun_d = 1'b1;
        if (xfer) begin
          if (beat_q == BeatMax) begin
            beat_d = '0;
            if (row_q == RowMax) begin
              row_d   = '0;
              state_d = StFlush;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StFlush: begin
        if (result_valid) overrun_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      beat_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      beat_q    <= beat_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SYSTOLIC_DRAIN_CAPTURE_EN
  logic [MatW-1:0] matrix_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      matrix_q <= '0;
    end else if (accept) begin
      matrix_q <= result_flat;
    end
  end

  assign src        = matrix_q;
  assign array_hold = 1'b0;
`else
  // Without a snapshot the array must stay frozen until the last beat has left.
  assign src        = result_flat;
  assign array_hold = (state_q != StIdle);
  logic unused_accept;
  assign unused_accept = accept;
`endif

  systolic_drain_addr_gen #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .ROW_W      (RowW),
    .BEAT_W     (BeatW)
  ) u_addr_gen (
    .row    (row_q),
    .beat   (beat_q),
    .matrix (src),
    .lanes  (lane_data)
  );

  assign m.m_valid    = (state_q == StStream);
  assign m.m_data     = m.m_valid ? lane_data : '0;
  assign m.m_row_last = m.m_valid && (beat_q == BeatMax);
  assign m.m_last     = m.m_row_last && (row_q == RowMax);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench: queue-based beat model compared every cycle, plus directed literal checks.
module tb_systolic_result_drain;

  localparam int unsigned A     = 4;
  localparam int unsigned L     = 2;
  localparam int unsigned DW    = 16;
  localparam int unsigned NBEAT = A * A / L;

  typedef struct {
    logic [L*DW-1:0] data;
    bit              row_last;
    bit              last;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                result_valid = 1'b0;
  logic [DW*A*A-1:0]   flat;
  logic                array_hold;
  logic                overrun;

  systolic_result_drain_if #(.LANES(L), .DATA_WIDTH(DW)) bus ();

  systolic_result_drain #(
    .ARRAY_SIZE (A),
    .DATA_WIDTH (DW),
    .LANES      (L)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .result_valid (result_valid),
    .result_flat  (flat),
    .array_hold   (array_hold),
    .overrun      (overrun),
    .m            (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  // Reference model: pending beats of the accepted matrix, plus one idle-but-busy flush cycle.
  beat_t exp_q[$];
  bit    m_flush = 1'b0;
  bit    m_ovr   = 1'b0;
  bit    capture_mode;

  function automatic void fill_expected();
    for (int r = 0; r < int'(A); r++) begin
      for (int b = 0; b < int'(A / L); b++) begin
        beat_t bt;
        bt.data = '0;
        for (int k = 0; k < int'(L); k++) begin
          bt.data[k*DW +: DW] = flat[(r * int'(A) + b * int'(L) + k) * int'(DW) +: DW];
        end
        bt.row_last = (b == int'(A / L) - 1);
        bt.last     = bt.row_last && (r == int'(A) - 1);
        exp_q.push_back(bt);
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_flush = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      bit was_busy;
      bit new_flush;
      was_busy  = (exp_q.size() != 0) || m_flush;
      new_flush = 1'b0;
      if (exp_q.size() != 0 && bus.m_ready) begin
        if (exp_q[0].last) new_flush = 1'b1;
        void'(exp_q.pop_front());
      end
      m_flush = new_flush;
      if (result_valid) begin
        if (was_busy) m_ovr = 1'b1;
        else fill_expected();
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit              ev;
    logic [L*DW-1:0] ed;
    bit              erl, el, eh;
    ev  = (exp_q.size() != 0);
    ed  = ev ? exp_q[0].data : '0;
    erl = ev ? exp_q[0].row_last : 1'b0;
    el  = ev ? exp_q[0].last : 1'b0;
    eh  = capture_mode ? 1'b0 : (ev || m_flush);
    chk("m_valid", 64'(bus.m_valid), 64'(ev));
    chk("m_data", 64'(bus.m_data), 64'(ed));
    chk("m_row_last", 64'(bus.m_row_last), 64'(erl));
    chk("m_last", 64'(bus.m_last), 64'(el));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("array_hold", 64'(array_hold), 64'(eh));
  end

  // Log of beats actually transferred, for the literal expectations.
  beat_t log_q[$];
  always @(posedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      beat_t bt;
      bt.data     = bus.m_data;
      bt.row_last = bus.m_row_last;
      bt.last     = bus.m_last;
      log_q.push_back(bt);
    end
  end

  int hold_cnt = 0;
  always @(negedge clk) if (array_hold) hold_cnt++;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse();
    result_valid = 1'b1;
    step(1);
    result_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input string name);
    int t = 0;
    while (log_q.size() < n && t < 200) begin
      step(1);
      t++;
    end
    if (log_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d beats want %0d", name, log_q.size(), n);
    end
  endtask

  task automatic set_pattern();
    for (int r = 0; r < int'(A); r++)
      for (int c = 0; c < int'(A); c++)
        flat[(r * int'(A) + c) * int'(DW) +: DW] = 16'(16 * r + c);
  endtask

  initial begin
`ifdef SYSTOLIC_DRAIN_CAPTURE_EN
    capture_mode = 1'b1;
`else
    capture_mode = 1'b0;
`endif
    bus.m_ready = 1'b1;
    set_pattern();
    step(2);
    chk("reset_valid", 64'(bus.m_valid), 64'd0);
    chk("reset_hold", 64'(array_hold), 64'd0);
    rst = 1'b0;
    step(1);

    // Basic stream
    log_q.delete();
    hold_cnt = 0;
    pulse();
    wait_log(NBEAT, "basic");
    step(3);
    chk("basic_count", 64'(log_q.size()), 64'(NBEAT));
    if (log_q.size() == NBEAT) begin
      chk("basic_beat0", 64'(log_q[0].data), 64'h0001_0000);
      chk("basic_beat7", 64'(log_q[7].data), 64'h0033_0032);
      for (int i = 0; i < int'(NBEAT); i++) begin
        chk("basic_row_last", 64'(log_q[i].row_last), 64'(i % 2 == 1));
        chk("basic_last", 64'(log_q[i].last), 64'(i == 7));
      end
    end
    chk("basic_hold_cycles", 64'(hold_cnt), capture_mode ? 64'd0 : 64'd9);

    // Backpressure at beat 2
    log_q.delete();
    pulse();
    wait_log(2, "bp_pre");
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 64'(bus.m_valid), 64'd1);
      chk("bp_data", 64'(bus.m_data), 64'h0011_0010);
      step(1);
    end
    bus.m_ready = 1'b1;
    wait_log(NBEAT, "bp");
    step(3);
    chk("bp_count", 64'(log_q.size()), 64'(NBEAT));

    // Overrun at beat 4
    log_q.delete();
    pulse();
    wait_log(4, "ovr_pre");
    pulse();
    wait_log(NBEAT, "ovr");
    step(8);
    chk("ovr_flag", 64'(overrun), 64'd1);
    chk("ovr_count", 64'(log_q.size()), 64'(NBEAT));

    // Reset mid-stream at beat 3
    log_q.delete();
    pulse();
    wait_log(3, "rst_pre");
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_data", 64'(bus.m_data), 64'd0);
    chk("rst_last", 64'(bus.m_last), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_hold", 64'(array_hold), 64'd0);
    step(1);
    rst = 1'b0;
    step(6);
    chk("rst_no_beats", 64'(log_q.size()), 64'd3);

    // Capture: in capture mode the array may change right after the pulse
    log_q.delete();
    hold_cnt = 0;
    pulse();
    if (capture_mode) flat = '1;
    wait_log(NBEAT, "cap");
    step(3);
    if (log_q.size() == NBEAT) chk("cap_beat5", 64'(log_q[5].data), 64'h0023_0022);
    chk("cap_hold_cycles", 64'(hold_cnt), capture_mode ? 64'd0 : 64'd9);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.m_ready  = ($urandom % 4) != 0;
      result_valid = ($urandom % 12) == 0;
      if (capture_mode || (exp_q.size() == 0 && !m_flush)) begin
        for (int w = 0; w < int'(A * A); w++) flat[w*DW +: DW] = 16'($urandom);
      end
      step(1);
    end
    result_valid = 1'b0;
    bus.m_ready  = 1'b1;
    step(40);
    chk("final_idle", 64'(bus.m_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
